dice_roll_sequencer: RTL

//  Control FSM sequencing the dice counter datapath. Inputs: debounced die-select buttons and the 32 Hz prescaler tick.

---
 rtl/dice_roll_sequencer_pkg.sv | 41 ++++
 rtl/dice_roll_sequencer_settle.sv | 75 +++++++
 rtl/dice_roll_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dice_roll_sequencer_pkg.sv
// Shared types and helpers for the dice roll sequencer.
// State encodings and the die side-count table.
package dice_roll_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SPIN   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SHOW   = 3'd4
  } state_e;

  localparam int unsigned NUM_DICE = 7;

  // Side count per button index; 0 for an invalid index.
  function automatic logic [6:0] die_sides(input logic [2:0] idx);
    logic [6:0] s;
    case (idx)
      3'd0:    s = 7'd4;
      3'd1:    s = 7'd6;
      3'd2:    s = 7'd8;
      3'd3:    s = 7'd10;
      3'd4:    s = 7'd12;
      3'd5:    s = 7'd20;
      3'd6:    s = 7'd100;
      default: s = 7'd0;
    endcase
    return s;
  endfunction

  // Index of the lowest set bit; 0 when none set.
  function automatic logic [2:0] first_set(input logic [6:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dice_roll_sequencer_settle.sv
// Deceleration timer for the settle phase.
// Issues step requests at growing tick gaps.
module settle_timer
  import dice_roll_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_STEPS = 6,
  parameter int unsigned GAP_INC      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  input  logic step_ack,
  output logic step_req,
  output logic done
);

  localparam logic [3:0] STEPS = 4'(SETTLE_STEPS);
  localparam logic [4:0] INC   = 5'(GAP_INC);

  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] step_cnt_q, step_cnt_d;
  logic       req_q, req_d;
  logic       active_q, active_d;
  logic [4:0] gap_sum;

  assign step_req = req_q;
  assign done     = active_q & ~req_q & (step_cnt_q == STEPS);

  // Tick counting, step request issue and gap growth on acceptance.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    gap_d      = gap_q;
    step_cnt_d = step_cnt_q;
    req_d      = req_q;
    active_d   = active_q;
    gap_sum    = {1'b0, gap_q} + INC;
    if (start) begin
      tick_cnt_d = '0;
      gap_d      = 4'd1;
      step_cnt_d = '0;
      req_d      = 1'b0;
      active_d   = 1'b1;
    end else if (active_q) begin
      if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
      if (req_q && step_ack) begin
        req_d      = 1'b0;
        step_cnt_d = step_cnt_q + 4'd1;
        gap_d      = (gap_sum > 5'd15) ? 4'd15 : gap_sum[3:0];
      end else if (!req_q && !done && tick_cnt_d == gap_q) begin
        req_d      = 1'b1;
        tick_cnt_d = '0;
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      gap_q      <= '0;
      step_cnt_q <= '0;
      req_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      gap_q      <= gap_d;
      step_cnt_q <= step_cnt_d;
      req_q      <= req_d;
      active_q   <= active_d;
    end
  end

endmodule

// File: rtl/dice_roll_sequencer.sv
// Dice roll control FSM: load/step commands to the
// digit counter and display gating.
module dice_roll_sequencer
  import dice_roll_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_STEPS = 6,
  parameter int unsigned GAP_INC      = 1,
  parameter int unsigned SHOW_FLASH   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [6:0] btn,
  input  logic       cmd_ready,
  output logic       cmd_load,
  output logic       cmd_step,
  output logic [6:0] cmd_sides,
  output logic       display_en,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [6:0] btn_prev_q;
  logic [2:0] sel_q, sel_d;
  logic       load_q, load_d;
  logic       spin_q, spin_d;
  logic [6:0] sides_q, sides_d;
  logic       disp_q, disp_d;
  logic       busy_q, busy_d;

  logic [6:0] rise;
  logic [2:0] first;
  logic       held;
  logic       in_settle;
  logic       tmr_start;
  logic       tmr_req;
  logic       tmr_done;
  logic       tmr_ack;

  assign rise      = btn & ~btn_prev_q;
  assign first     = first_set(rise);
  assign held      = btn[sel_q];
  assign in_settle = (state_q == ST_SETTLE);
  assign tmr_ack   = in_settle & tmr_req & cmd_ready;

  assign cmd_load   = load_q;
  assign cmd_step   = spin_q | (in_settle & tmr_req);
  assign cmd_sides  = sides_q;
  assign display_en = disp_q;
  assign busy       = busy_q;

  settle_timer #(
    .SETTLE_STEPS (SETTLE_STEPS),
    .GAP_INC      (GAP_INC)
  ) u_settle (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .tick     (tick & in_settle),
    .step_ack (tmr_ack),
    .step_req (tmr_req),
    .done     (tmr_done)
  );

  // Next state and registered output values.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    load_d    = load_q;
    spin_d    = spin_q;
    sides_d   = sides_q;
    disp_d    = disp_q;
    busy_d    = busy_q;
    tmr_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_SHOW: begin
        load_d = 1'b0;
        spin_d = 1'b0;
        disp_d = 1'b1;
        busy_d = 1'b0;
        if (|rise) begin
          sel_d   = first;
          sides_d = die_sides(first);
          load_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cmd_ready) begin
          load_d = 1'b0;
          disp_d = 1'b0;
          if (held) begin
            spin_d  = 1'b1;
            state_d = ST_SPIN;
          end else begin
            tmr_start = 1'b1;
            state_d   = ST_SETTLE;
          end
        end
      end
      ST_SPIN: begin
        disp_d = 1'b0;
        if (!held) begin
          spin_d    = 1'b0;
          tmr_start = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          disp_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_SHOW;
        end else if (tick) begin
          disp_d = (SHOW_FLASH != 0) ? ~disp_q : 1'b0;
        end
      end
      default: begin
        load_d  = 1'b0;
        spin_d  = 1'b0;
        disp_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Previous button levels for edge detect; follows btn through reset.
  always_ff @(posedge clk) begin
    btn_prev_q <= btn;
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      load_q  <= 1'b0;
      spin_q  <= 1'b0;
      sides_q <= '0;
      disp_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      spin_q  <= spin_d;
      sides_q <= sides_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
    end
  end

endmodule
